// File: rtl/axi_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_apb_pkg
// Brief   : Shared types and constants for the AXI4-Lite to APB front end.
// Revision: 1.0 - initial release
// ============================================================================
package axi_apb_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_B_RESP   = 3'd3,
        S_R_RESP   = 3'd4
    } state_t;

    // Grant encoding doubles as the arbiter request index.
    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_apb_rw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_apb_rw_scheduler_if
// Brief   : AXI4-Lite slave bundle plus single-command req/ack sequencer link.
// Revision: 1.0 - initial release
// ============================================================================
interface axi_apb_rw_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    // Scheduler view
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // AXI master / sequencer view
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/axi_apb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : axi_apb_rr_arb2
// Brief   : Two-input round-robin picker with registered last grant.
// Revision: 1.0 - initial release
// ============================================================================
module axi_apb_rr_arb2 #(
    parameter logic RST_LAST = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic [1:0] i_req,
    output logic            o_valid,
    output logic            o_gnt
);
    logic r_last;

    // On a tie the input that did not win last time goes next.
    always_comb begin
        o_valid = |i_req;
        o_gnt   = 1'b0;
        if (&i_req) begin
            o_gnt = ~r_last;
        end else if (i_req[1]) begin
            o_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= RST_LAST;
        end else if (i_en && o_valid) begin
            r_last <= o_gnt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_apb_rw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : axi_apb_rw_scheduler
// Brief   : Buffers one AXI-Lite read and one write, issues them one at a time.
// Revision: 1.0 - initial release
// ============================================================================
module axi_apb_rw_scheduler
    import axi_apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic               s_axi_clk,
    input  wire logic               s_axi_reset,
    axi_apb_rw_scheduler_if.slave   bus
);
    localparam int c_strb_w = DATA_W / 8;
    localparam int c_cnt_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    state_t                r_state, w_next;
    logic                  r_ar_held, r_aw_held, r_w_held;
    logic [ADDR_W-1:0]     r_araddr, r_awaddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_strb_w-1:0]   r_wstrb;
    logic                  r_cmd_write;
    logic [ADDR_W-1:0]     r_cmd_addr;
    logic [DATA_W-1:0]     r_cmd_wdata;
    logic [c_strb_w-1:0]   r_cmd_wstrb;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_W-1:0]     r_rdata;
    logic                  w_grant_en, w_timeout_hit;
    logic                  w_arb_valid, w_arb_gnt;
    grant_t                w_gnt;

    assign bus.arready   = !r_ar_held;
    assign bus.awready   = !r_aw_held;
    assign bus.wready    = !r_w_held;
    assign bus.cmd_valid = (r_state == S_ISSUE);
    assign bus.bvalid    = (r_state == S_B_RESP);
    assign bus.rvalid    = (r_state == S_R_RESP);
    assign bus.cmd_write = r_cmd_write;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.cmd_wdata = r_cmd_wdata;
    assign bus.cmd_wstrb = r_cmd_wstrb;
    assign bus.bresp     = r_bresp;
    assign bus.rresp     = r_rresp;
    assign bus.rdata     = r_rdata;
    assign w_gnt         = grant_t'(w_arb_gnt);

    axi_apb_rr_arb2 #(
        .RST_LAST (GNT_WRITE)
    ) u_arb (
        .clk     (s_axi_clk),
        .rst     (s_axi_reset),
        .i_en    (w_grant_en),
        .i_req   ({r_aw_held && r_w_held, r_ar_held}),
        .o_valid (w_arb_valid),
        .o_gnt   (w_arb_gnt)
    );

    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_grant_en    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_en = 1'b1;
                    w_next     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ready) w_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    w_next = r_cmd_write ? S_B_RESP : S_R_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_to_last)) begin
                    w_timeout_hit = 1'b1;
                    w_next        = r_cmd_write ? S_B_RESP : S_R_RESP;
                end
            end
            S_B_RESP: begin
                if (bus.bready) w_next = S_IDLE;
            end
            S_R_RESP: begin
                if (bus.rready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            r_ar_held   <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_araddr    <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_wstrb <= '0;
            r_cnt       <= '0;
            r_bresp     <= c_resp_okay;
            r_rresp     <= c_resp_okay;
            r_rdata     <= '0;
        end else begin
            if (bus.arvalid && !r_ar_held) begin
                r_ar_held <= 1'b1;
                r_araddr  <= bus.araddr;
            end else if ((r_state == S_R_RESP) && bus.rready) begin
                r_ar_held <= 1'b0;
            end

            if (bus.awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= bus.awaddr;
            end else if ((r_state == S_B_RESP) && bus.bready) begin
                r_aw_held <= 1'b0;
            end

            if (bus.wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= bus.wdata;
                r_wstrb  <= bus.wstrb;
            end else if ((r_state == S_B_RESP) && bus.bready) begin
                r_w_held <= 1'b0;
            end

            if (w_grant_en) begin
                r_cmd_write <= (w_gnt == GNT_WRITE);
                r_cmd_addr  <= (w_gnt == GNT_WRITE) ? r_awaddr : r_araddr;
                r_cmd_wdata <= (w_gnt == GNT_WRITE) ? r_wdata : '0;
                r_cmd_wstrb <= (w_gnt == GNT_WRITE) ? r_wstrb : '0;
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_RSP) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Responses only move while waiting, so they hold through B/R stalls.
            if ((r_state == S_WAIT_RSP) && bus.rsp_valid) begin
                if (r_cmd_write) begin
                    r_bresp <= bus.rsp_err ? c_resp_slverr : c_resp_okay;
                end else begin
                    r_rresp <= bus.rsp_err ? c_resp_slverr : c_resp_okay;
                    r_rdata <= bus.rsp_rdata;
                end
            end else if (w_timeout_hit) begin
                if (r_cmd_write) begin
                    r_bresp <= c_resp_slverr;
                end else begin
                    r_rresp <= c_resp_slverr;
                    r_rdata <= '0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_apb_rw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_apb_rw_scheduler
// Brief   : Directed scoreboard bench for the AXI-Lite read/write scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_apb_rw_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [68:0] q_cmd[$];
    logic [33:0] q_r[$];
    logic [1:0]  q_b[$];

    always #5 clk = ~clk;

    axi_apb_rw_scheduler_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_apb_rw_scheduler #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .s_axi_clk   (clk),
        .s_axi_reset (rst),
        .bus         (bus)
    );

    function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (q_cmd.size() == 0) check("unexpected cmd", 96'd1, 96'd0);
                else check("cmd", {27'd0, bus.cmd_write, bus.cmd_addr,
                                   bus.cmd_write ? bus.cmd_wdata : 32'd0,
                                   bus.cmd_write ? bus.cmd_wstrb : 4'd0}, {27'd0, q_cmd.pop_front()});
            end
            if (bus.rvalid && bus.rready) begin
                if (q_r.size() == 0) check("unexpected R", 96'd1, 96'd0);
                else check("R resp/data", {62'd0, bus.rresp, bus.rdata}, {62'd0, q_r.pop_front()});
            end
            if (bus.bvalid && bus.bready) begin
                if (q_b.size() == 0) check("unexpected B", 96'd1, 96'd0);
                else check("B resp", {94'd0, bus.bresp}, {94'd0, q_b.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!bus.arready && n < 40) begin clk1(); n++; end
        clk1();
        bus.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        while (!bus.awready && n < 40) begin clk1(); n++; end
        clk1();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        while (!bus.wready && n < 40) begin clk1(); n++; end
        clk1();
        bus.wvalid = 1'b0;
    endtask

    // Waits for the command handshake, then completes it after d cycles in WAIT_RSP.
    task automatic serve(input logic is_wr, input int d, input logic [31:0] rd, input logic err);
        int n = 0;
        while (!bus.cmd_valid && n < 40) begin clk1(); n++; end
        if (!bus.cmd_valid) begin
            check("cmd_valid wait", 96'd0, 96'd1);
            return;
        end
        clk1();
        repeat (d) clk1();
        bus.rsp_valid = 1'b1; bus.rsp_rdata = rd; bus.rsp_err = err;
        clk1();
        bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
        check("rsp->valid latency", {95'd0, is_wr ? bus.bvalid : bus.rvalid}, 96'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((bus.rvalid || bus.bvalid) && n < 40) begin clk1(); n++; end
        check("response drained", {94'd0, bus.rvalid, bus.bvalid}, 96'd0);
    endtask

    task automatic quiet(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            check(name, {93'd0, bus.cmd_valid, bus.rvalid, bus.bvalid}, 96'd0);
            clk1();
        end
    endtask

    initial begin
        int n;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1; bus.cmd_ready = 1'b1; bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0; bus.rsp_err = 1'b0;

        rst = 1'b1;
        repeat (3) clk1();
        check("reset handshakes", {90'd0, bus.arready, bus.awready, bus.wready,
                                   bus.bvalid, bus.rvalid, bus.cmd_valid}, 96'b111000);
        check("reset resp/rdata", {60'd0, bus.bresp, bus.rresp, bus.rdata}, 96'd0);
        check("reset cmd", {27'd0, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb}, 96'd0);
        rst = 1'b0;
        clk1();

        // Single read
        q_cmd.push_back({1'b0, 32'h0000_0400, 32'd0, 4'd0});
        q_r.push_back({2'b00, 32'hDEAD_BEEF});
        send_ar(32'h0000_0400);
        serve(1'b0, 2, 32'hDEAD_BEEF, 1'b0);
        wait_done();

        // W leads AW by four cycles; error response
        send_w(32'h1234_5678, 4'hF);
        quiet(4, "no cmd before AW");
        q_cmd.push_back({1'b1, 32'h0000_0800, 32'h1234_5678, 4'hF});
        q_b.push_back(2'b10);
        send_aw(32'h0000_0800);
        serve(1'b1, 1, 32'd0, 1'b1);
        wait_done();

        // Simultaneous AR and AW+W after reset: grants alternate R,W,R,W
        rst = 1'b1; clk1(); rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("readies open", {93'd0, bus.arready, bus.awready, bus.wready}, 96'b111);
            bus.araddr = 32'h100 * (k + 1); bus.arvalid = 1'b1;
            bus.awaddr = 32'h100 * (k + 1) + 4; bus.awvalid = 1'b1;
            bus.wdata = 32'hCAFE_F000 + k; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            clk1();
            bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            q_cmd.push_back({1'b0, 32'h100 * (k + 1), 32'd0, 4'd0});
            q_cmd.push_back({1'b1, 32'h100 * (k + 1) + 4, 32'hCAFE_F000 + k, 4'hF});
            q_r.push_back({(k == 1) ? 2'b10 : 2'b00, 32'h1111_1111 * (k + 1)});
            q_b.push_back(2'b00);
            serve(1'b0, 0, 32'h1111_1111 * (k + 1), k == 1);
            wait_done();
            serve(1'b1, 2, 32'd0, 1'b0);
            wait_done();
        end

        // Timeout: no completion, forced SLVERR with zero data after 16 cycles
        q_cmd.push_back({1'b0, 32'h0000_0010, 32'd0, 4'd0});
        q_r.push_back({2'b10, 32'd0});
        send_ar(32'h0000_0010);
        n = 0;
        while (!bus.cmd_valid && n < 40) begin clk1(); n++; end
        clk1();
        n = 0;
        while (!bus.rvalid && n < 40) begin clk1(); n++; end
        check("timeout cycles", 96'(n), 96'd16);
        repeat (5) clk1();
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hBAD0_BAD0;
        clk1();
        bus.rsp_valid = 1'b0;
        quiet(4, "late rsp ignored");

        // B stall: bvalid/bresp hold, new AW blocked until B handshake
        bus.bready = 1'b0;
        q_cmd.push_back({1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'h3});
        q_b.push_back(2'b00);
        send_aw(32'h0000_0020);
        send_w(32'hA5A5_A5A5, 4'h3);
        serve(1'b1, 0, 32'd0, 1'b0);
        bus.awaddr = 32'h0000_0024; bus.awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("B held stable", {93'd0, bus.bvalid, bus.bresp}, 96'b100);
            check("awready blocked", {95'd0, bus.awready}, 96'd0);
            clk1();
        end
        bus.bready = 1'b1;
        clk1();
        check("awready reopened", {95'd0, bus.awready}, 96'd1);
        clk1();
        bus.awvalid = 1'b0;
        q_cmd.push_back({1'b1, 32'h0000_0024, 32'h5555_0000, 4'hC});
        q_b.push_back(2'b00);
        send_w(32'h5555_0000, 4'hC);
        serve(1'b1, 0, 32'd0, 1'b0);
        wait_done();

        // Reset while waiting for the completion
        q_cmd.push_back({1'b0, 32'h0000_0030, 32'd0, 4'd0});
        send_ar(32'h0000_0030);
        n = 0;
        while (!bus.cmd_valid && n < 40) begin clk1(); n++; end
        clk1();
        clk1();
        rst = 1'b1; clk1(); rst = 1'b0;
        check("post-reset state", {90'd0, bus.arready, bus.awready, bus.wready,
                                   bus.bvalid, bus.rvalid, bus.cmd_valid}, 96'b111000);
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h7777_7777;
        clk1();
        bus.rsp_valid = 1'b0;
        quiet(5, "rsp after reset ignored");

        check("scoreboard empty", 96'(q_cmd.size() + q_r.size() + q_b.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
